// File: rtl/ycfsm_seq.sv
// Clocked four-phase sequencer for one asynchronous ycfsm cell (or cell chain).
// Optional wait-state timeout/abort is compiled in with `define YCSEQ_TIMEOUT_EN.
module ycfsm_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rst,
  input  logic [1:0] cmd_in,
  input  logic [1:0] cmd_match,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_out,
  output logic       rsp_err,
  output logic       cell_reset,
  output logic [1:0] cell_in,
  output logic [1:0] cell_match,
  input  logic [1:0] cell_out,
  output logic       busy
);

  localparam int unsigned CW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [1:0] C_ILLEGAL = 2'b11;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RST_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("ycfsm_seq: parameter out of legal range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RSTW, S_DRIVE, S_WVAL, S_CLR, S_WEMP, S_RESP, S_TRST
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync [SYNC_STAGES];
  logic [1:0]      r_sout_d;
  logic [CW-1:0]   r_cnt;
  logic            r_cmd_ready;
  logic            r_busy;
  logic            r_rsp_valid;
  logic [1:0]      r_rsp_out;
  logic            r_rsp_err;
  logic            r_cell_reset;
  logic [1:0]      r_cell_in;
  logic [1:0]      r_cell_match;

  logic [1:0]      w_sout;
  logic            w_full;
  logic            w_empty;

  // Extra delayed copy of sout: a code is trusted only once two successive samples agree.
  assign w_sout  = r_sync[SYNC_STAGES-1];
  assign w_full  = (w_sout == r_sout_d) && (w_sout != 2'b00);
  assign w_empty = (w_sout == r_sout_d) && (w_sout == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sout_d <= '0;
    end else begin
      r_sync[0] <= cell_out;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sout_d <= w_sout;
    end
  end

`ifdef YCSEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmd_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_out    <= '0;
      r_rsp_err    <= 1'b0;
      r_cell_reset <= 1'b0;
      r_cell_in    <= '0;
      r_cell_match <= '0;
`ifdef YCSEQ_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_rst) begin
              r_cell_reset <= 1'b1;
              r_cnt        <= CW'(RST_CYCLES - 1);
              r_state      <= S_RST;
            end else if (cmd_in == C_ILLEGAL || cmd_match == C_ILLEGAL) begin
              r_rsp_out   <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_cell_in    <= cmd_in;
              r_cell_match <= cmd_match;
              r_state      <= S_DRIVE;
            end
          end
        end
        S_RST: begin
          if (r_cnt == '0) begin
            r_cell_reset <= 1'b0;
            r_state      <= S_RSTW;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RSTW: begin
          if (w_empty) begin
            r_rsp_out   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_DRIVE: r_state <= S_WVAL;
        S_WVAL: begin
          if (w_full) begin
            r_rsp_out <= w_sout;
            r_rsp_err <= (w_sout == C_ILLEGAL);
            r_state   <= S_CLR;
          end
        end
        S_CLR: begin
          r_cell_in    <= '0;
          r_cell_match <= '0;
          r_state      <= S_WEMP;
        end
        S_WEMP: begin
          if (w_empty) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_TRST: begin
          if (r_cnt == '0) begin
            r_cell_reset <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef YCSEQ_TIMEOUT_EN
      // Placed after the case so an abort overrides any same-cycle normal exit.
      if (r_state == S_WVAL || r_state == S_WEMP || r_state == S_RSTW) begin
        if (r_tmo == TW'(TIMEOUT)) begin
          r_cell_in    <= '0;
          r_cell_match <= '0;
          r_cell_reset <= 1'b1;
          r_cnt        <= CW'(RST_CYCLES - 1);
          r_rsp_out    <= w_sout;
          r_rsp_err    <= 1'b1;
          r_rsp_valid  <= 1'b0;
          r_state      <= S_TRST;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
`endif
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_out    = r_rsp_out;
  assign rsp_err    = r_rsp_err;
  assign cell_reset = r_cell_reset;
  assign cell_in    = r_cell_in;
  assign cell_match = r_cell_match;

endmodule

// File: tb/tb_ycfsm_seq.sv
// Randomized scoreboard bench for ycfsm_seq with a behavioural ycfsm cell model.
module tb_ycfsm_seq;
  localparam int S  = 2;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rst = 1'b0;
  logic [1:0] cmd_in = '0, cmd_match = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [1:0] rsp_out;
  logic       cell_reset, busy;
  logic [1:0] cell_in, cell_match, cell_out;

  ycfsm_seq #(.SYNC_STAGES(S), .RST_CYCLES(RC), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rst(cmd_rst), .cmd_in(cmd_in), .cmd_match(cmd_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_err(rsp_err),
    .cell_reset(cell_reset), .cell_in(cell_in), .cell_match(cell_match),
    .cell_out(cell_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] out;
    logic       err;
    int         acc;
    int         kind;  // 0 normal, 1 reset cmd, 2 illegal, 3 timeout
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  bit   cell_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cell model: value appears only when both rails are non-empty; V0 against V1 glitches to 11.
  function automatic logic [1:0] cell_fn(input logic [1:0] i, input logic [1:0] m);
    if (i == 2'b00 || m == 2'b00) return 2'b00;
    if (i == m) return i;
    if (i == 2'b01) return 2'b11;
    return 2'b01;
  endfunction

  initial begin
    logic [1:0] tgt;
    cell_out = 2'b00;
    forever begin
      @(negedge clk);
      tgt = (cell_reset || cell_stall) ? 2'b00 : cell_fn(cell_in, cell_match);
      if (cell_out != tgt && $urandom_range(0, 1) == 1) cell_out = tgt;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = (bp_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pulse width, latency, hold-stability and scoreboard compare.
  initial begin
    bit         prev_valid = 1'b0, held = 1'b0;
    logic [1:0] held_out;
    logic       held_err;
    int         rst_hi = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 1'b0; held = 1'b0; rst_hi = 0;
      end else begin
        if (cell_reset) rst_hi++;
        else if (rst_hi != 0) begin
          chk("cell_reset_width", rst_hi, RC);
          rst_hi = 0;
        end
        if (rsp_valid && !prev_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          if (e.kind == 0) begin
            chk("min_latency", (cyc - e.acc >= 2*S + 5) ? 1 : 0, 1);
            chk("cell_empty_at_rsp", {cell_in, cell_out}, 4'b0000);
          end
          if (e.kind == 2) chk("illegal_latency", (cyc - e.acc <= 2) ? 1 : 0, 1);
        end
        if (rsp_valid) begin
          chk("cmd_ready_low_in_rsp", cmd_ready, 0);
          if (held) chk("rsp_hold_stable", {rsp_out, rsp_err}, {held_out, held_err});
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_out", rsp_out, e.out);
            chk("rsp_err", rsp_err, e.err);
          end
        end
        prev_valid = rsp_valid;
        held       = rsp_valid && !rsp_ready;
        held_out   = rsp_out;
        held_err   = rsp_err;
      end
    end
  end

  task automatic send(input logic rst, input logic [1:0] i, input logic [1:0] m, input bit stuck);
    exp_t e;
    int   n = 0;
    cmd_rst = rst; cmd_in = i; cmd_match = m; cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 3000);
    if (!cmd_ready) begin
      chk("cmd_ready_wait_expired", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e.acc = cyc;
    if (rst) begin e.out = 2'b00; e.err = 1'b0; e.kind = 1; end
    else if (i == 2'b11 || m == 2'b11) begin e.out = 2'b00; e.err = 1'b1; e.kind = 2; end
    else if (stuck) begin e.out = 2'b00; e.err = 1'b1; e.kind = 3; end
    else begin e.out = cell_fn(i, m); e.err = (e.out == 2'b11); e.kind = 0; end
    exp_q.push_back(e);
    if (e.kind == 0) chk("cell_drive", {cell_in, cell_match}, {i, m});
    if (e.kind == 2) chk("illegal_cell_untouched", {cell_in, cell_match}, 4'b0000);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_expired", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [1:0] ri, rm;
    int n;
    #2;
    chk("reset_outputs", {rsp_valid, rsp_out, rsp_err, cell_reset, cell_in, cell_match, busy}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", cmd_ready, 1);

    send(0, 2'b10, 2'b10, 0);   // match V1
    send(0, 2'b10, 2'b01, 0);   // mismatch
    send(0, 2'b01, 2'b10, 0);   // glitch code 11 -> error
    send(1, 2'b00, 2'b00, 0);   // reset command
    send(0, 2'b11, 2'b01, 0);   // illegal input
    send(0, 2'b01, 2'b11, 0);
    drain();

    bp_mode = 1;
    send(0, 2'b01, 2'b01, 0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_rsp_arrived", rsp_valid, 1);
    repeat (10) @(negedge clk);
    bp_mode = 0;
    drain();

    for (int k = 0; k < 60; k++) begin
      ri = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      rm = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      case ($urandom_range(0, 7))
        0: send(1, ri, rm, 0);
        1: send(0, 2'b11, rm, 0);
        default: send(0, ri, rm, 0);
      endcase
    end
    drain();

`ifdef YCSEQ_TIMEOUT_EN
    cell_stall = 1'b1;
    send(0, 2'b10, 2'b10, 1);
    drain();
    cell_stall = 1'b0;
`endif

    cell_stall = 1'b1;
    send(0, 2'b10, 2'b10, 0);
    repeat (6) @(negedge clk);
    chk("busy_in_wait", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {rsp_valid, rsp_out, rsp_err, cell_reset, cell_in, cell_match, busy}, 0);
    exp_q.delete();
    cell_stall = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midop_reset", cmd_ready, 1);
    send(0, 2'b01, 2'b01, 0);
    drain();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_time_limit", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ycfsm_seq.md
Name: ycfsm_seq

Overview:
Synchronous sequencer that drives one asynchronous ycfsm cell, or a chain of cells, from a clocked test or configuration host. It accepts commands over a valid/ready interface and applies them to the cell's dual-rail `in` and `match` inputs. Each command runs a full four-phase cycle: drive value, wait for `out` valid, return to empty, wait for `out` empty. The sampled result is returned over a valid/ready response channel. It sits between the clocked host logic and the self-timed Morphle fabric.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing cell_out into clk; legal range 2..4.
- RST_CYCLES, 4, number of clk cycles cell_reset is held high for a reset command; must be at least 1.
- TIMEOUT, 255, cycles to wait in either wait state before aborting; used only when YCSEQ_TIMEOUT_EN is defined. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts a command this cycle
- cmd_rst  in  1  command is a cell reset; cmd_in and cmd_match are ignored
- cmd_in  in  2  dual-rail value for cell in
- cmd_match  in  2  dual-rail value for cell match
- rsp_valid  out  1  response present
- rsp_ready  in  1  host takes the response
- rsp_out  out  2  synchronized cell_out value captured in the valid phase
- rsp_err  out  1  response is an error (illegal code or timeout)
- cell_reset  out  1  active-high reset to the cell
- cell_in  out  2  to cell in
- cell_match  out  2  to cell match
- cell_out  in  2  from cell out (asynchronous)
- busy  out  1  FSM is not in IDLE

Behaviour:
- Encoding: Vempty=00, V0=01, V1=10; 11 is illegal.
- Async reset (reset_n low) forces:
  - state = IDLE
  - cell_reset = 0
  - cell_in = cell_match = 00
  - rsp_valid = 0, rsp_out = 00, rsp_err = 0
  - synchronizer flops = 00
  - all counters = 0
- Reset release is synchronous to clk on the first edge after reset_n goes high.
- All outputs are registered. cmd_ready = (state == IDLE).
- Synchronized output `sout` is the last stage of the SYNC_STAGES chain. The synchronizer is a per-bit flop chain; a code is only acted on after it has been stable for 2 consecutive cycles.
- State transitions:
  - IDLE: on cmd_valid, accept the command.
    - cmd_rst=1 -> RST; cell_reset=1; count = RST_CYCLES-1.
    - cmd_in==11 or cmd_match==11 -> RESP with rsp_err=1, rsp_out=00; the cell is not touched.
    - Otherwise -> DRIVE; register cell_in=cmd_in and cell_match=cmd_match.
  - RST: decrement count; at 0 -> RSTW with cell_reset=0.
  - RSTW: wait until sout==00 stable -> RESP with rsp_out=00, rsp_err=0.
  - DRIVE: one cycle of settling -> WVAL.
  - WVAL: when sout!=00 and stable, capture rsp_out=sout -> CLR. If the captured code is 11, set rsp_err=1.
  - CLR: cell_in=cell_match=00 -> WEMP.
  - WEMP: when sout==00 and stable -> RESP.
  - RESP: rsp_valid=1; hold rsp_out and rsp_err stable until rsp_ready. On the cycle rsp_valid && rsp_ready, clear rsp_valid -> IDLE. cmd_ready rises the cycle after the handshake, so back-to-back commands are spaced by at least 1 idle cycle.
- Command with cmd_in=Vempty and non-empty match: the cell may never produce a value. Without the timeout feature the FSM waits in WVAL indefinitely; this is legal host misuse.
- cmd_valid is ignored outside IDLE; the host must hold the command until cmd_ready.
- reset_n asserted mid-operation: immediate return to the reset values above; any in-flight response is lost.
- Minimum latency from accept to rsp_valid is DRIVE(1) + WVAL(SYNC_STAGES+1) + CLR(1) + WEMP(SYNC_STAGES+1) + 1.

Optional Feature:
- Macro YCSEQ_TIMEOUT_EN.
- Defined: a cycle counter cleared on entry to WVAL, WEMP and RSTW. When it reaches TIMEOUT:
  - cell_in, cell_match = 00
  - cell_reset is pulsed for RST_CYCLES
  - the FSM then goes to RESP with rsp_err=1 and rsp_out=sout.
- Not defined: the counter and that logic are absent, and the wait states have no exit other than the cell responding or reset_n.

Test Plan:
- Reset: hold reset_n=0 mid-WVAL -> all outputs at reset values asynchronously; cmd_ready=1 on the first clk after release.
- Match: cmd in=V1, match=V1 with cell model -> cell_in=10, cell_match=10; rsp_out=V1 (10), rsp_err=0; cell returns to 00 before rsp_valid.
- Mismatch: cmd in=V1, match=V0 -> rsp_out equals the model's mismatch code; rsp_err=0.
- Reset command: cmd_rst=1 -> cell_reset high for exactly 4 cycles; rsp_out=00, rsp_err=0.
- Illegal input: cmd_in=11 -> rsp_valid with rsp_err=1 within 2 cycles; cell_in stays 00.
- Backpressure and timeout: hold rsp_ready=0 for 10 cycles -> rsp_out stable and cmd_ready=0 throughout. With YCSEQ_TIMEOUT_EN and the cell stuck empty -> rsp_err=1 after 255 cycles in WVAL.
